// File: rtl/axi_master_cmd_pkg.sv
// Shared AXI types and constants for the single-outstanding command master.
package axi_master_cmd_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [7:0]  len_t;
  typedef logic [2:0]  size_t;
  typedef logic [1:0]  burst_t;
  typedef logic [1:0]  resp_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic logic resp_is_err(input resp_t resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_master_cmd_if.sv
// AXI bus bundle (AW/W/B/AR/R) with master and slave views.
interface AXI_if;
  import axi_master_cmd_pkg::*;

  logic   awvalid;
  logic   awready;
  addr_t  awaddr;
  len_t   awlen;
  size_t  awsize;
  burst_t awburst;

  logic   wvalid;
  logic   wready;
  data_t  wdata;
  logic   wlast;

  logic   bvalid;
  logic   bready;
  resp_t  bresp;

  logic   arvalid;
  logic   arready;
  addr_t  araddr;
  len_t   arlen;
  size_t  arsize;
  burst_t arburst;

  logic   rvalid;
  logic   rready;
  data_t  rdata;
  resp_t  rresp;
  logic   rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_master_beat_ctr.sv
// Beat counter for the active burst; last_o flags the final beat (count == len).
module axi_master_beat_ctr
  import axi_master_cmd_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  input  len_t len_i,
  output logic last_o
);

  len_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + len_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_master_cmd.sv
// Single-outstanding AXI burst master: turns one user command into an AR/R or AW/W/B
// exchange and reports completion with a one-cycle done pulse plus an error flag.
module axi_master_cmd
  import axi_master_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 7
) (
  input  logic   aclk,
  input  logic   areset_n,
  AXI_if.master  m_axi,
  input  logic   cmd_valid,
  output logic   cmd_ready,
  input  logic   cmd_write,
  input  addr_t  cmd_addr,
  input  len_t   cmd_len,
  input  size_t  cmd_size,
  input  burst_t cmd_burst,
  input  data_t  usr_wdata,
  input  logic   usr_wvalid,
  output logic   usr_wready,
  output data_t  usr_rdata,
  output logic   usr_rvalid,
  output logic   usr_rlast,
  output logic   done,
  output logic   done_err
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

  state_e state_q, state_d;
  addr_t  addr_q, addr_d;
  len_t   len_q, len_d;
  size_t  size_q, size_d;
  burst_t burst_q, burst_d;
  logic   err_q, err_d;
  logic   rej_q, rej_d;
  logic   live_q;

  logic cmd_hs, len_bad, last;
  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic cur_err, finish;

  // live_q keeps cmd_ready low while reset is held and until the first edge after release.
  assign cmd_ready = live_q && (state_q == StIdle);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign len_bad   = 32'(cmd_len) > MAX_LEN;

  assign m_axi.arvalid = (state_q == StAr);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = burst_q;
  assign m_axi.awvalid = (state_q == StAw);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = burst_q;
  assign m_axi.wvalid  = (state_q == StW) && usr_wvalid;
  assign m_axi.wdata   = usr_wdata;
  assign m_axi.wlast   = (state_q == StW) && last;
  assign m_axi.bready  = (state_q == StB);
  assign m_axi.rready  = (state_q == StR);

  assign ar_hs = m_axi.arvalid && m_axi.arready;
  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign r_hs  = (state_q == StR) && m_axi.rvalid;
  assign w_hs  = m_axi.wvalid && m_axi.wready;
  assign b_hs  = (state_q == StB) && m_axi.bvalid;

  assign usr_wready = (state_q == StW) && m_axi.wready;
  assign usr_rvalid = r_hs;
  assign usr_rdata  = m_axi.rdata;
  assign usr_rlast  = r_hs && last;

  // A read beat is also in error when the slave's rlast disagrees with our own count.
  assign cur_err = (r_hs && (resp_is_err(m_axi.rresp) || (m_axi.rlast != last))) ||
                   (b_hs && resp_is_err(m_axi.bresp));
  assign finish   = (r_hs && last) || b_hs;
  assign done     = rej_q || finish;
  assign done_err = rej_q || (finish && (err_q || cur_err));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    rej_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (cmd_hs) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          if (len_bad) begin
            rej_d = 1'b1;
          end else begin
            state_d = cmd_write ? StAw : StAr;
          end
        end
      end
      StAr: if (ar_hs) state_d = StR;
      StR: begin
        err_d = err_q || cur_err;
        if (r_hs && last) state_d = StIdle;
      end
      StAw: if (aw_hs) state_d = StW;
      StW:  if (w_hs && last) state_d = StB;
      StB:  if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      rej_q   <= rej_d;
      live_q  <= 1'b1;
    end
  end

  axi_master_beat_ctr u_beat_ctr (
    .clk_i  (aclk),
    .rst_ni (areset_n),
    .clr_i  (state_q == StIdle),
    .inc_i  (r_hs || w_hs),
    .len_i  (len_q),
    .last_o (last)
  );

endmodule

// File: tb/tb_axi_master_cmd.sv
// Bench for axi_master_cmd: slave model with memory, table-driven and random commands
// checked against a reference memory, plus reset sequences.
module tb_axi_master_cmd;
  import axi_master_cmd_pkg::*;

  localparam int unsigned MaxLen = 7;

  logic   aclk = 1'b0;
  logic   areset_n;
  logic   cmd_valid, cmd_ready, cmd_write;
  addr_t  cmd_addr;
  len_t   cmd_len;
  size_t  cmd_size;
  burst_t cmd_burst;
  data_t  usr_wdata, usr_rdata;
  logic   usr_wvalid, usr_wready, usr_rvalid, usr_rlast;
  logic   done, done_err;

  always #5 aclk = ~aclk;

  AXI_if m_axi ();

  axi_master_cmd #(.MAX_LEN(MaxLen)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .m_axi     (m_axi),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .usr_wdata (usr_wdata),
    .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready),
    .usr_rdata (usr_rdata),
    .usr_rvalid(usr_rvalid),
    .usr_rlast (usr_rlast),
    .done      (done),
    .done_err  (done_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic   wr;
    addr_t  addr;
    len_t   len;
    burst_t burst;
    data_t  wbase;
    int     aw_dly;
    int     ar_dly;
    resp_t  bresp;
    resp_t  rresp;
    bit     rlast_bad;
    int     wv_mode;   // 0 always valid, 1 every other cycle, 2 random
    logic   exp_err;
  } vec_t;

  function automatic vec_t mk(logic wr, addr_t addr, len_t len, burst_t burst, data_t wbase,
                              int aw_dly, int ar_dly, resp_t bresp, resp_t rresp,
                              bit rlast_bad, int wv_mode, logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.wbase = wbase;
    v.aw_dly = aw_dly; v.ar_dly = ar_dly; v.bresp = bresp; v.rresp = rresp;
    v.rlast_bad = rlast_bad; v.wv_mode = wv_mode; v.exp_err = exp_err;
    return v;
  endfunction

  // Spec-level error rule: oversize command, any bad response, or an rlast that is misplaced.
  function automatic logic model_err(vec_t v);
    if (int'(v.len) > int'(MaxLen)) return 1'b1;
    if (v.wr) return v.bresp != RESP_OKAY;
    return (v.rresp != RESP_OKAY) || v.rlast_bad;
  endfunction

  // Slave knobs and state
  int     k_aw_dly, k_ar_dly;
  resp_t  k_bresp, k_rresp;
  bit     k_rlast_bad, k_rand;
  addr_t  k_addr;
  len_t   k_len;

  data_t      smem [256];
  data_t      ref_mem [256];
  logic [7:0] wr_base, rd_base;
  len_t       wr_len, rd_len;
  bit         wr_fixed, rd_fixed, b_pend, r_act, aw_wait;
  int         widx, ridx, aw_cnt, ar_cnt;
  addr_t      aw_prev;

  initial begin
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = RESP_OKAY;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = RESP_OKAY;
    m_axi.rlast = 1'b0;
    b_pend = 0; r_act = 0; aw_cnt = 0; ar_cnt = 0; aw_wait = 0; widx = 0; ridx = 0;
    forever begin
      @(negedge aclk);
      m_axi.awready = m_axi.awvalid && (aw_cnt >= k_aw_dly);
      m_axi.arready = m_axi.arvalid && (ar_cnt >= k_ar_dly);
      m_axi.wready  = k_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi.bvalid  = b_pend;
      m_axi.bresp   = b_pend ? k_bresp : RESP_OKAY;
      if (r_act && (!k_rand || $urandom_range(0, 3) != 0)) begin
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = smem[rd_fixed ? rd_base : rd_base + 8'(ridx)];
        m_axi.rlast  = (ridx == int'(rd_len)) ^ (k_rlast_bad && ridx == 0);
        m_axi.rresp  = k_rresp;
      end else begin
        m_axi.rvalid = 1'b0;
        m_axi.rlast  = 1'b0;
        m_axi.rresp  = RESP_OKAY;
      end
      #1;
      if (!areset_n) begin
        b_pend = 0; r_act = 0; aw_cnt = 0; ar_cnt = 0; aw_wait = 0;
      end else begin
        if (m_axi.awvalid && aw_wait) check("awaddr_stable", m_axi.awaddr, aw_prev);
        aw_wait = m_axi.awvalid && !m_axi.awready;
        aw_prev = m_axi.awaddr;
        if (m_axi.awvalid && m_axi.awready) begin
          check("awaddr", m_axi.awaddr, k_addr);
          check("awlen", m_axi.awlen, k_len);
          wr_base = m_axi.awaddr[9:2]; wr_len = m_axi.awlen;
          wr_fixed = (m_axi.awburst == BURST_FIXED); widx = 0; aw_cnt = 0;
        end else if (m_axi.awvalid) begin
          aw_cnt++;
        end
        if (m_axi.wvalid && m_axi.wready) begin
          smem[wr_fixed ? wr_base : wr_base + 8'(widx)] = m_axi.wdata;
          check("wlast", m_axi.wlast, widx == int'(wr_len));
          if (m_axi.wlast) b_pend = 1;
          widx++;
        end
        if (m_axi.bvalid && m_axi.bready) b_pend = 0;
        if (m_axi.arvalid && m_axi.arready) begin
          check("araddr", m_axi.araddr, k_addr);
          check("arlen", m_axi.arlen, k_len);
          rd_base = m_axi.araddr[9:2]; rd_len = m_axi.arlen;
          rd_fixed = (m_axi.arburst == BURST_FIXED); ridx = 0; ar_cnt = 0; r_act = 1;
        end else if (m_axi.arvalid) begin
          ar_cnt++;
        end
        if (m_axi.rvalid && m_axi.rready) begin
          ridx++;
          if (ridx > int'(rd_len)) r_act = 0;
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge aclk);
    areset_n = 1'b0; cmd_valid = 1'b0; usr_wvalid = 1'b0;
    repeat (cycles) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
  endtask

  task automatic run_cmd(input vec_t v, input bit rnd);
    data_t wq[$];
    data_t rq[$];
    data_t exp_q[$];
    bit    got_done = 0, saw_ax = 0, derr = 0;
    int    cyc = 0, done_cyc = -1, rlast_at = -1, extra = 0, busy_rdy = 0;
    bit    bad = int'(v.len) > int'(MaxLen);
    for (int i = 0; i <= int'(v.len); i++) begin
      logic [7:0] idx = v.addr[9:2] + ((v.burst == BURST_FIXED) ? 8'd0 : 8'(i));
      wq.push_back(rnd ? data_t'($urandom) : v.wbase + data_t'(i));
      exp_q.push_back(ref_mem[idx]);
    end
    k_aw_dly = v.aw_dly; k_ar_dly = v.ar_dly; k_bresp = v.bresp; k_rresp = v.rresp;
    k_rlast_bad = v.rlast_bad; k_rand = rnd; k_addr = v.addr; k_len = v.len;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    cmd_size = 3'd2; cmd_burst = v.burst;
    #1;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    while (!got_done && cyc < 300) begin
      @(negedge aclk);
      cmd_valid = 1'b0;
      if (v.wr && wq.size() > 0) begin
        unique case (v.wv_mode)
          0:       usr_wvalid = 1'b1;
          1:       usr_wvalid = (cyc % 2 == 0);
          default: usr_wvalid = 1'($urandom_range(0, 1));
        endcase
        usr_wdata = wq[0];
      end else begin
        usr_wvalid = 1'b0;
      end
      #1;
      if (m_axi.awvalid || m_axi.arvalid) saw_ax = 1;
      if (cmd_ready && !done && !bad) busy_rdy++;
      if (usr_wvalid && usr_wready) void'(wq.pop_front());
      if (usr_rvalid) begin
        rq.push_back(usr_rdata);
        if (usr_rlast) rlast_at = rq.size() - 1;
      end
      if (done) begin
        got_done = 1; derr = done_err; done_cyc = cyc;
      end
      cyc++;
    end
    usr_wvalid = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      #1;
      if (done) extra++;
      if (m_axi.awvalid || m_axi.arvalid) saw_ax = 1;
    end
    check("done_seen", got_done, 1'b1);
    check("done_err", derr, v.exp_err);
    check("extra_done", extra, 0);
    if (bad) begin
      check("rej_no_axi", saw_ax, 1'b0);
      check("rej_latency", done_cyc, 0);
    end else if (v.wr) begin
      check("busy_cmd_ready", busy_rdy, 0);
      check("w_beats_left", wq.size(), 0);
      for (int i = 0; i <= int'(v.len); i++) begin
        logic [7:0] idx = v.addr[9:2] + ((v.burst == BURST_FIXED) ? 8'd0 : 8'(i));
        ref_mem[idx] = rnd ? smem[idx] : v.wbase + data_t'(i);
      end
    end else begin
      check("busy_cmd_ready", busy_rdy, 0);
      check("r_beats", rq.size(), int'(v.len) + 1);
      for (int i = 0; i < rq.size() && i < exp_q.size(); i++) check("rdata", rq[i], exp_q[i]);
      check("rlast_pos", rlast_at, int'(v.len));
    end
    if (!got_done) do_reset(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   wcount, cyc, dseen;

    areset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = BURST_INCR; usr_wdata = '0; usr_wvalid = 1'b0;
    k_aw_dly = 0; k_ar_dly = 0; k_bresp = RESP_OKAY; k_rresp = RESP_OKAY;
    k_rlast_bad = 0; k_rand = 0; k_addr = '0; k_len = '0;
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0; ref_mem[i] = '0;
    end

    // Reset state and cmd_ready timing around release
    repeat (3) @(negedge aclk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.wlast}, 4'b0);
    check("rst_readies", {m_axi.bready, m_axi.rready, usr_wready, usr_rvalid, usr_rlast}, 5'b0);
    check("rst_done", {done, done_err}, 2'b0);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    check("cmd_ready_before_edge", cmd_ready, 1'b0);
    @(negedge aclk);
    #1;
    check("cmd_ready_after_edge", cmd_ready, 1'b1);

    vecs.push_back(mk(1, 'h000, 3, BURST_INCR,  'hA0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(0, 'h000, 3, BURST_INCR,  0,    0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 'h100, 8, BURST_INCR,  'h11, 0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 1));
    vecs.push_back(mk(0, 'h100, 8, BURST_INCR,  0,    0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 1));
    vecs.push_back(mk(1, 'h040, 3, BURST_INCR,  'hB0, 5, 0, RESP_OKAY,   RESP_OKAY,   0, 1, 0));
    vecs.push_back(mk(0, 'h040, 3, BURST_INCR,  0,    0, 3, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 'h080, 1, BURST_INCR,  'hC0, 0, 0, RESP_SLVERR, RESP_OKAY,   0, 0, 1));
    vecs.push_back(mk(1, 'h080, 1, BURST_INCR,  'hC8, 0, 0, RESP_OKAY,   RESP_OKAY,   0, 1, 0));
    vecs.push_back(mk(0, 'h080, 1, BURST_INCR,  0,    0, 0, RESP_OKAY,   RESP_SLVERR, 0, 0, 1));
    vecs.push_back(mk(0, 'h000, 3, BURST_INCR,  0,    0, 0, RESP_OKAY,   RESP_OKAY,   1, 0, 1));
    vecs.push_back(mk(0, 'h000, 0, BURST_FIXED, 0,    0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 'h0C0, 2, BURST_FIXED, 'hD0, 0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(0, 'h0C0, 0, BURST_INCR,  0,    0, 0, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 'h200, 7, BURST_INCR,  'hE0, 1, 0, RESP_OKAY,   RESP_OKAY,   0, 2, 0));
    vecs.push_back(mk(0, 'h200, 7, BURST_INCR,  0,    0, 1, RESP_OKAY,   RESP_OKAY,   0, 0, 0));
    foreach (vecs[i]) run_cmd(vecs[i], 1'b0);

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.wr        = 1'($urandom_range(0, 1));
      v.addr      = addr_t'($urandom_range(0, 239)) << 2;
      v.len       = ($urandom_range(0, 5) == 0) ? len_t'(8) : len_t'($urandom_range(0, 7));
      v.burst     = ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR;
      v.wbase     = '0;
      v.aw_dly    = $urandom_range(0, 3);
      v.ar_dly    = $urandom_range(0, 3);
      v.bresp     = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
      v.rresp     = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
      v.rlast_bad = ($urandom_range(0, 9) == 0);
      v.wv_mode   = 2;
      v.exp_err   = model_err(v);
      run_cmd(v, 1'b1);
    end

    // Reset during beat 2 of a len-3 write: burst abandoned, no done pulse
    k_aw_dly = 0; k_rand = 0; k_bresp = RESP_OKAY; k_addr = 'h3C0; k_len = 3;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 'h3C0; cmd_len = 3; cmd_burst = BURST_INCR;
    wcount = 0; cyc = 0; dseen = 0;
    while (wcount < 1 && cyc < 50) begin
      @(negedge aclk);
      cmd_valid = 1'b0; usr_wvalid = 1'b1; usr_wdata = 'hF0 + data_t'(wcount);
      #1;
      if (usr_wvalid && usr_wready) wcount++;
      if (done) dseen++;
      cyc++;
    end
    check("rst_mid_beat1", wcount, 1);
    @(negedge aclk);
    areset_n = 1'b0; usr_wdata = 'hF1;
    #1;
    if (done) dseen++;
    @(negedge aclk);
    usr_wvalid = 1'b0;
    #1;
    check("mid_rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.wlast}, 4'b0);
    check("mid_rst_user", {usr_wready, usr_rvalid, usr_rlast, cmd_ready}, 4'b0);
    check("mid_rst_resp", {m_axi.bready, m_axi.rready}, 2'b0);
    if (done) dseen++;
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    if (done) dseen++;
    @(negedge aclk);
    #1;
    if (done) dseen++;
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_no_done", dseen, 0);
    run_cmd(mk(0, 'h000, 3, BURST_INCR, 0, 0, 0, RESP_OKAY, RESP_OKAY, 0, 0, 0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_cmd.md
AXI_MASTER_CMD -- requirements
Module: axi_master_cmd

Interface
REQ-001 Parameter MAX_LEN, default 7, is the largest accepted burst len; the downstream slave buffer holds 8 beats.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 aclk  input  1  clock carried on m_axi; every flop samples on its rising edge.
REQ-004 areset_n  input  1  synchronous active-low reset carried on m_axi.
REQ-005 m_axi  modport AXI_if.master  -  drives AW/W/AR valid and payload plus bready/rready; samples the ready and response signals.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr/cmd_len/cmd_size/cmd_burst  input  addr_t/len_t/size_t/burst_t  burst attributes.
REQ-010 usr_wdata  input  data_t  write beat data.
REQ-011 usr_wvalid / usr_wready  input / output  1  write beat stream handshake.
REQ-012 usr_rdata  output  data_t  read beat data.
REQ-013 usr_rvalid / usr_rlast  output  1  read beat valid (no backpressure) / final beat.
REQ-014 done / done_err  output  1  one-cycle completion pulse / error flag qualified by done.

Function
REQ-015 States SHALL be IDLE, AR, R, AW, W, B.
REQ-016 cmd_ready SHALL be 1 only in IDLE.
REQ-017 On a cmd handshake, cmd_addr, cmd_len, cmd_size and cmd_burst SHALL be latched; the FSM moves to AW if cmd_write=1, else to AR.
REQ-018 A command with cmd_len > MAX_LEN SHALL stay in IDLE, produce no AXI activity, and pulse done=1 with done_err=1 on the next cycle.
REQ-019 In AR, arvalid=1 with the latched attributes held stable until arvalid&&arready; AW behaves the same with awvalid.
REQ-020 Valid SHALL never wait on ready; arvalid/awvalid SHALL be asserted on the first cycle in AR/AW.
REQ-021 In R, rready=1; each rvalid&&rready SHALL drive usr_rvalid=1 and usr_rdata=rdata in the same cycle and increment beat_cnt.
REQ-022 The R state SHALL exit to IDLE on the handshake where beat_cnt==len, with usr_rlast=1 and done=1 on that cycle.
REQ-023 In W, wvalid=usr_wvalid, wdata=usr_wdata and usr_wready=wready (all combinational); wlast=1 when beat_cnt==len.
REQ-024 On the wlast handshake the FSM SHALL move to B; bready=1 in B; on bvalid&&bready, done=1 and the FSM returns to IDLE.
REQ-025 done_err SHALL be 1 if any rresp/bresp != RESP_OKAY, or if rlast disagrees with beat_cnt==len on any read handshake.
REQ-026 beat_cnt SHALL be len_t wide, clear in IDLE, and never wrap within a legal burst (len <= MAX_LEN).
REQ-027 arvalid, awvalid, wvalid, usr_wready and usr_rvalid SHALL all be 0 outside their own state.
REQ-028 Only one transaction SHALL be outstanding; cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-029 With areset_n=0 at an edge: state=IDLE, beat_cnt=0, latched attributes=0, error accumulator=0.
REQ-030 Every valid/ready/last output, done and done_err SHALL be 0 from the first edge where areset_n=0.
REQ-031 A reset taken mid-burst SHALL abandon the burst with no done pulse; cmd_ready=1 on the first edge after areset_n=1.

Structure
REQ-032 addr_t, data_t, len_t, size_t and burst_t SHALL come from the shared AXI package, along with BURST_INCR/BURST_FIXED and RESP_OKAY; the state enum stays local to the module.
REQ-033 Sub-module axi_master_beat_ctr SHALL hold beat_cnt and produce last = (beat_cnt==len); all other logic stays in axi_master_cmd.

Verification
REQ-034 Write INCR, addr 0, len 3, data 0xA0..0xA3 into the slave model -> 4 W beats, wlast on beat 4 only, done=1 with done_err=0 after bvalid.
REQ-035 Read INCR, addr 0, len 3 after REQ-034 -> usr_rdata 0xA0,0xA1,0xA2,0xA3, usr_rlast on the 4th beat, done=1, done_err=0.
REQ-036 cmd_len=8 with MAX_LEN=7 -> no arvalid/awvalid ever asserted; done=1 and done_err=1 one cycle after the handshake.
REQ-037 Slave holds awready=0 for 5 cycles, and usr_wvalid toggles every other cycle -> awaddr stable throughout, no beat lost or duplicated.
REQ-038 Slave returns bresp=SLVERR -> done=1 with done_err=1; the next command still completes with done_err=0.
REQ-039 areset_n=0 asserted during W beat 2 of a len-3 write -> all valids 0 at the next edge, no done pulse, a fresh read completes normally.
